// File: rtl/alu_seq_ctrl_if.sv
// Host/controller/datapath signal bundle for alu_seq_ctrl; slave is the controller's view.
interface alu_seq_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_a;
    logic [3:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [11:0] alu_datain;
    logic        alu_ld_a;
    logic        alu_ld_b;
    logic        alu_cmp;
    logic        alu_add;
    logic        alu_sub;
    logic        alu_div;
    logic        alu_mul;
    logic [7:0]  alu_y;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_y,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, alu_datain,
               alu_ld_a, alu_ld_b, alu_cmp, alu_add, alu_sub, alu_div, alu_mul
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_y,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, alu_datain,
               alu_ld_a, alu_ld_b, alu_cmp, alu_add, alu_sub, alu_div, alu_mul
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// One-at-a-time ALU sequencer: response 4+RES_LAT cycles after accept, held until rsp_ready.
// ALU_CTRL_DIVZERO_EN: reject DIV with B=0 without strobing the datapath.
module alu_seq_ctrl #(
    parameter int RES_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDA  = 3'd1;
    localparam logic [2:0] S_LDB  = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0] state;
    logic [2:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] cnt;
    logic [7:0] data_q;
    logic       err_q;
    logic       cmd_illegal;
    logic       accept;
    logic       op_act;

    always_comb begin
        cmd_illegal = (bus.cmd_op > 3'd4);
`ifdef ALU_CTRL_DIVZERO_EN
        if (bus.cmd_op == 3'd3 && bus.cmd_b == 4'h0) cmd_illegal = 1'b1;
`endif
    end

    assign accept = bus.cmd_valid && (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= 3'd0;
            a_q    <= 4'h0;
            b_q    <= 4'h0;
            cnt    <= 4'h0;
            data_q <= 8'h00;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= bus.cmd_op;
                        a_q  <= bus.cmd_a;
                        b_q  <= bus.cmd_b;
                        if (cmd_illegal) begin
                            data_q <= 8'h00;
                            err_q  <= 1'b1;
                            state  <= S_RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= S_LDA;
                        end
                    end
                end
                S_LDA:  state <= S_LDB;
                S_LDB:  state <= S_EXEC;
                S_EXEC: begin
                    cnt   <= 4'(RES_LAT);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Op select is still asserted this cycle, so alu_y has settled for RES_LAT+1 cycles.
                    if (cnt == 4'd1) begin
                        data_q <= bus.alu_y;
                        state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign op_act = (state == S_EXEC) || (state == S_WAIT);

    assign bus.cmd_ready  = (state == S_IDLE) && !rst;
    assign bus.rsp_valid  = (state == S_RESP);
    assign bus.rsp_data   = data_q;
    assign bus.rsp_err    = err_q;
    assign bus.alu_datain = {4'h0, b_q, a_q};
    assign bus.alu_ld_a   = (state == S_LDA);
    assign bus.alu_ld_b   = (state == S_LDB);
    assign bus.alu_cmp    = op_act && (op_q == 3'd0);
    assign bus.alu_add    = op_act && (op_q == 3'd1);
    assign bus.alu_sub    = op_act && (op_q == 3'd2);
    assign bus.alu_div    = op_act && (op_q == 3'd3);
    assign bus.alu_mul    = op_act && (op_q == 3'd4);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural datapath, per-cycle strobe/timing checks, response scoreboard.
module tb_alu_seq_ctrl;

    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_ctrl_if bus();

    alu_seq_ctrl #(.RES_LAT(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [3:0] dp_a  = 4'h0;
    logic [3:0] dp_b  = 4'h0;

    function automatic logic [7:0] calc(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    calc = (a == b) ? 8'h01 : 8'h00;
            3'd1:    calc = 8'(a) + 8'(b);
            3'd2:    calc = 8'(a) - 8'(b);
            3'd3:    calc = (b == 4'h0) ? 8'hFF : 8'(a / b);
            3'd4:    calc = 8'(a) * 8'(b);
            default: calc = 8'h00;
        endcase
    endfunction

    // Datapath stand-in: registers load on the strobes, result selected by the op strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.alu_ld_a) dp_a <= bus.alu_datain[3:0];
        if (bus.alu_ld_b) dp_b <= bus.alu_datain[7:4];
    end

    always_comb begin
        bus.alu_y = 8'h00;
        if (bus.alu_cmp)      bus.alu_y = calc(3'd0, dp_a, dp_b);
        else if (bus.alu_add) bus.alu_y = calc(3'd1, dp_a, dp_b);
        else if (bus.alu_sub) bus.alu_y = calc(3'd2, dp_a, dp_b);
        else if (bus.alu_div) bus.alu_y = calc(3'd3, dp_a, dp_b);
        else if (bus.alu_mul) bus.alu_y = calc(3'd4, dp_a, dp_b);
    end

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ops_now();
        return {bus.alu_mul, bus.alu_div, bus.alu_sub, bus.alu_add, bus.alu_cmp};
    endfunction

    // Called at a negedge with the controller idle; returns at the negedge after the handshake.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input int hold, input int abort_at, output int acc);
        logic legal;
        int   exp_cyc;
        int   left;
        bit   seen;
        bit   done;
        rsp_t ex;
        rsp_t got;
        logic [4:0] exp_ops;

        legal = (op <= 3'd4);
`ifdef ALU_CTRL_DIVZERO_EN
        if (op == 3'd3 && b == 4'h0) legal = 1'b0;
`endif
        exp_cyc = legal ? 4 + RL : 1;
        ex.data = legal ? calc(op, a, b) : 8'h00;
        ex.err  = !legal;
        left = hold;
        seen = 1'b0;
        done = 1'b0;

        chk("cmd_ready_idle", 12'(bus.cmd_ready), 12'd1);
        bus.rsp_ready = (hold == 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        sb.push_back(ex);
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = op ^ 3'd1;
        bus.cmd_a     = ~a;
        bus.cmd_b     = ~b;

        for (int k = 1; k <= 40 && !done; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_ld", 12'({bus.alu_ld_a, bus.alu_ld_b}), 12'd0);
                chk("rst_ops", 12'(ops_now()), 12'd0);
                chk("rst_rsp_valid", 12'(bus.rsp_valid), 12'd0);
                chk("rst_datain", bus.alu_datain, 12'h000);
                chk("rst_rsp_data", 12'({bus.rsp_err, bus.rsp_data}), 12'h000);
                void'(sb.pop_back());
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("rst_release_ready", 12'(bus.cmd_ready), 12'd1);
                @(negedge clk);
                done = 1'b1;
            end else begin
                exp_ops = (legal && k >= 3 && k <= 3 + RL) ? (5'b00001 << op) : 5'b00000;
                chk("ld_a", 12'(bus.alu_ld_a), 12'(legal && k == 1));
                chk("ld_b", 12'(bus.alu_ld_b), 12'(legal && k == 2));
                chk("op_strobe", 12'(ops_now()), 12'(exp_ops));
                chk("onehot", 12'($countones({bus.alu_ld_a, bus.alu_ld_b, ops_now()}) <= 1), 12'd1);
                if (!seen) begin
                    chk("rsp_valid_timing", 12'(bus.rsp_valid), 12'(k >= exp_cyc));
                    chk("cmd_ready_busy", 12'(bus.cmd_ready), 12'd0);
                    if (k == exp_cyc) begin
                        seen = 1'b1;
                        if (sb.size() == 0) begin
                            chk("sb_empty", 12'd1, 12'd0);
                        end else begin
                            got = sb.pop_front();
                            chk("rsp_data", 12'(bus.rsp_data), 12'(got.data));
                            chk("rsp_err", 12'(bus.rsp_err), 12'(got.err));
                        end
                    end
                end else if (bus.rsp_ready) begin
                    chk("post_hs_valid", 12'(bus.rsp_valid), 12'd0);
                    chk("post_hs_ready", 12'(bus.cmd_ready), 12'd1);
                    done = 1'b1;
                end else begin
                    chk("hold_valid", 12'(bus.rsp_valid), 12'd1);
                    chk("hold_data", 12'({bus.rsp_err, bus.rsp_data}), 12'({ex.err, ex.data}));
                    chk("hold_cmd_ready", 12'(bus.cmd_ready), 12'd0);
                end
                if (seen && !bus.rsp_ready && !done) begin
                    if (left <= 1) bus.rsp_ready = 1'b1;
                    else left--;
                end
                if (!done) @(negedge clk);
            end
        end
        if (!done) chk("timeout", 12'd0, 12'd1);
    endtask

    initial begin
        int acc;
        int prev;
        logic [2:0] rop;
        logic [3:0] ra;
        logic [3:0] rb;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 4'h0;
        bus.cmd_b     = 4'h0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_cmd_ready", 12'(bus.cmd_ready), 12'd1);
        chk("reset_rsp", 12'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}), 12'h000);
        chk("reset_strobes", 12'({bus.alu_ld_a, bus.alu_ld_b, ops_now()}), 12'd0);
        chk("reset_datain", bus.alu_datain, 12'h000);
        @(negedge clk);

        run_cmd(3'd1, 4'd3,  4'd5,  0,  0, acc);
        run_cmd(3'd4, 4'd15, 4'd15, 10, 0, acc);
        run_cmd(3'd6, 4'd1,  4'd2,  0,  0, acc);
        run_cmd(3'd3, 4'd9,  4'd0,  0,  0, acc);
        run_cmd(3'd2, 4'd12, 4'd5,  0,  4, acc);
        run_cmd(3'd0, 4'd2,  4'd2,  0,  0, acc);

        prev = 0;
        for (int i = 0; i < 4; i++) begin
            rop = 3'($urandom_range(0, 4));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(1, 15));
            run_cmd(rop, ra, rb, 0, 0, acc);
            if (i > 0) chk("accept_gap", 12'(acc - prev), 12'(5 + RL));
            prev = acc;
        end

        chk("sb_drained", 12'(sb.size()), 12'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the 4-bit ALU datapath. Accepts one operation at a time on a valid/ready command interface and drives the datapath's operand bus. It then pulses the A and B load strobes in turn, holds exactly one operation-select strobe while the result settles, and returns the 8-bit result on a valid/ready response interface. It sits between the host/test logic and the datapath and is the only driver of the datapath's control inputs.

## Interface
- RES_LAT, 2: cycles the op strobe is held after the EXEC cycle before the datapath result is sampled (legal 1–15).
- clk  in  1  rising-edge clock, shared with the datapath.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  0 CMP, 1 ADD, 2 SUB, 3 DIV, 4 MUL, 5–7 illegal.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  8  captured datapath result.
- rsp_err  out  1  command was rejected; rsp_data is 8'h00.
- alu_datain  out  12  datapath operand bus, {4'h0, B, A}; the datapath loads A from [3:0] and B from [7:4].
- alu_ld_a, alu_ld_b  out  1 each  datapath register load strobes.
- alu_cmp, alu_add, alu_sub, alu_div, alu_mul  out  1 each  op selects, one-hot or all zero.
- alu_y  in  8  datapath result.

## Operation
- FSM states: IDLE, LDA, LDB, EXEC, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op, A and B into internal registers.
  - Legal op: go to LDA.
  - Illegal op: go to RESP with err=1 and data 8'h00. No datapath strobes fire.
- alu_datain is driven from the latched registers and holds its value from LDA until the next accept.
- LDA: alu_ld_a=1 for one cycle, then go to LDB.
- LDB: alu_ld_b=1 for one cycle, then go to EXEC.
- EXEC: assert the selected op strobe, load the wait counter with RES_LAT, then go to WAIT.
- WAIT:
  - Keep the op strobe asserted and decrement the counter each cycle.
  - In the cycle the counter reaches 1, register alu_y into rsp_data and go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are stable.
  - All datapath strobes are 0.
  - On rsp_ready, go to IDLE.
- cmd_ready is 0 in every state except IDLE. The block has no command queueing and no accept in the same cycle as a response handshake.
- At most one of the ld/op strobes is high in any cycle.
- Reset values:
  - State IDLE.
  - cmd_ready=1 once reset is released.
  - rsp_valid=0, rsp_data=8'h00, rsp_err=0.
  - All strobes 0; alu_datain=12'h000; counter 0.
- Reset mid-operation: all outputs return to their reset values immediately. The in-flight command is dropped and no response is produced.
- cmd_* signals are ignored outside IDLE. Changes to them after accept have no effect.

## Timing
- Accept edge = cycle 0 (cmd_valid & cmd_ready sampled high).
- Cycle 1: alu_ld_a.
- Cycle 2: alu_ld_b.
- Cycles 3 to 3+RES_LAT: op strobe, RES_LAT+1 cycles in total.
- rsp_valid rises in cycle 4+RES_LAT, which is cycle 6 at the default RES_LAT.
- Illegal op: rsp_valid rises in cycle 1.
- Back-to-back throughput: one command per 5+RES_LAT cycles with rsp_ready tied high. The next accept is the cycle after the response handshake.
- rsp_valid may stay high indefinitely. rsp_data and rsp_err must not change while rsp_valid=1 and rsp_ready=0.

## Configuration
- ALU_CTRL_DIVZERO_EN defined:
  - A DIV command with cmd_b=0 is treated as illegal: go straight to RESP with rsp_err=1 and rsp_data=8'h00.
  - The datapath is never strobed for that command.
- ALU_CTRL_DIVZERO_EN undefined:
  - DIV with B=0 runs normally.
  - rsp_err=0 and rsp_data carries whatever alu_y returns.

## Test plan
- Reset, then ADD A=3, B=5; datapath model returns 8'h08 → ld_a in cycle 1, ld_b in cycle 2, alu_add high in cycles 3–5, rsp_valid in cycle 6 with rsp_data=8'h08 and rsp_err=0.
- MUL A=15, B=15 with rsp_ready held low for 10 cycles → rsp_data=8'hE1 held stable; cmd_ready=0 throughout; return to IDLE the cycle after rsp_ready.
- cmd_op=6 → rsp_valid in cycle 1 with rsp_err=1 and rsp_data=8'h00; no ld/op strobe ever high.
- DIV A=9, B=0 → with the macro: err=1 in cycle 1 and alu_div never asserted. Without the macro: alu_div held in cycles 3–5 and err=0.
- Assert rst during the WAIT of a SUB → all strobes 0 and rsp_valid=0 immediately; the next CMP A=2, B=2 completes normally in cycle 6.
- Four random legal ops with rsp_ready=1 → accepts exactly 7 cycles apart; strobe one-hot checked every cycle.
